// File: rtl/box_hit_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : box_hit_resolver                                                |
// | Purpose  : Ray sequencer and closest-hit reducer placed after the box      |
// |            tracer. For each accepted ray it walks the object table, feeds  |
// |            each box to the tracer, tracks the nearest intersection and     |
// |            hands one result per ray to the shading stage.                  |
// | Ports    : clk, rst          clock / synchronous active-high reset         |
// |            ray_valid/ready   ray handshake (init/dir held by upstream)     |
// |            obj_count         number of boxes to test, sampled at accept    |
// |            obj_addr/obj_data object table read port (1-cycle latency)      |
// |            trc_object        box presented to the tracer (registered)      |
// |            trc_t/trc_normal  tracer result, TRACE_LAT after trc_object     |
// |            hit_valid/ready   result handshake                              |
// |            hit_any/t/normal/id  nearest-hit result                         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module box_hit_resolver #(
  parameter int          OBJ_AW    = 4,
  parameter int          TRACE_LAT = 2,
  parameter logic [9:0]  T_MISS    = 10'h3FF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ray_valid,
  output logic              ray_ready,
  input  logic [OBJ_AW:0]   obj_count,
  output logic [OBJ_AW-1:0] obj_addr,
  input  logic [55:0]       obj_data,
  output logic [55:0]       trc_object,
  input  logic [9:0]        trc_t,
  input  logic [30:0]       trc_normal,
  output logic              hit_valid,
  input  logic              hit_ready,
  output logic              hit_any,
  output logic [9:0]        hit_t,
  output logic [30:0]       hit_normal,
  output logic [OBJ_AW-1:0] hit_id
);

  // Stage 0 holds the tag alongside obj_data; the tail lines up with trc_t.
  localparam int               c_TAG_DEPTH = 2 + TRACE_LAT;
  localparam logic [OBJ_AW:0]  c_ONE       = (OBJ_AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  logic [OBJ_AW:0]      r_count;
  logic [c_TAG_DEPTH-1:0] r_tag_v;
  logic [OBJ_AW-1:0]    r_tag_id [c_TAG_DEPTH];

  logic                 w_accept;
  logic                 w_tail_v;
  logic [OBJ_AW-1:0]    w_tail_id;
  logic [OBJ_AW:0]      w_addr_inc;
  logic [OBJ_AW:0]      w_tail_inc;
  logic                 w_take;

  assign ray_ready  = (r_state == ST_IDLE) && !rst;
  assign w_accept   = ray_valid && ray_ready;
  assign w_tail_v   = r_tag_v[c_TAG_DEPTH-1];
  assign w_tail_id  = r_tag_id[c_TAG_DEPTH-1];
  // Counts are compared one bit wider so a full table (2**OBJ_AW) is reachable.
  assign w_addr_inc = {1'b0, obj_addr}  + c_ONE;
  assign w_tail_inc = {1'b0, w_tail_id} + c_ONE;
  // Strict compare: equal t from a later (higher id) box never replaces.
  assign w_take     = w_tail_v && (trc_t != T_MISS) && (trc_t < hit_t);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_tag_v    <= '0;
      for (int k = 0; k < c_TAG_DEPTH; k++) r_tag_id[k] <= '0;
      obj_addr   <= '0;
      trc_object <= '0;
      hit_valid  <= 1'b0;
      hit_any    <= 1'b0;
      hit_t      <= T_MISS;
      hit_normal <= '0;
      hit_id     <= '0;
    end else begin
      // A tag enters for every address issued while streaming.
      r_tag_v     <= {r_tag_v[c_TAG_DEPTH-2:0], (r_state == ST_STREAM)};
      r_tag_id[0] <= obj_addr;
      for (int k = 1; k < c_TAG_DEPTH; k++) r_tag_id[k] <= r_tag_id[k-1];

      if (r_tag_v[0]) trc_object <= obj_data;

      if (w_take) begin
        hit_t      <= trc_t;
        hit_normal <= trc_normal;
        hit_id     <= w_tail_id;
        hit_any    <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            hit_t      <= T_MISS;
            hit_any    <= 1'b0;
            hit_normal <= '0;
            hit_id     <= '0;
            obj_addr   <= '0;
            r_count    <= obj_count;
            if (obj_count == '0) begin
              r_state   <= ST_DONE;
              hit_valid <= 1'b1;
            end else begin
              r_state   <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (w_addr_inc == r_count) r_state  <= ST_DRAIN;
          else                       obj_addr <= w_addr_inc[OBJ_AW-1:0];
        end
        ST_DRAIN: begin
          // Finish once the tag of the last box has been reduced.
          if (w_tail_v && (w_tail_inc == r_count)) begin
            r_state   <= ST_DONE;
            hit_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (hit_ready) begin
            r_state   <= ST_IDLE;
            hit_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
